// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU result path.
//   - ENTRY_W     : width of one queued result entry {err, result[5:0]}
//   - tx_state_t  : serial transmitter state encoding (IDLE=0 .. STOP=4)
//   - opcode_t    : ALSU opcode values, kept here so downstream logging blocks agree
//   - entry_parity: parity bit for one entry, even or odd
package alsu_pkg;

  localparam int ENTRY_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    OP_OR     = 3'd0,
    OP_XOR    = 3'd1,
    OP_ADD    = 3'd2,
    OP_MULT   = 3'd3,
    OP_SHIFT  = 3'd4,
    OP_ROTATE = 3'd5,
    OP_INV6   = 3'd6,
    OP_INV7   = 3'd7
  } opcode_t;

  // Even parity is the XOR of all entry bits; odd parity is its inverse.
  function automatic logic entry_parity(input logic [ENTRY_W-1:0] entry, input logic odd);
    return (^entry) ^ odd;
  endfunction

endpackage

// File: rtl/alsu_sync_fifo.sv
// Small synchronous FIFO with registered count/full/empty.
// Ports:
//   clk, rst (async, active-low)
//   push, wdata : write request and data; accepted when not full, or when a
//                 pop happens on the same edge
//   pop         : read request, ignored when empty
//   rdata       : head-of-queue entry (valid while !empty)
//   count       : entries queued, full / empty : registered flags
module alsu_sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CNT_W-1:0] count_next;

  // A full FIFO still accepts a write when the head leaves on the same edge.
  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + 1'b1;
    else if (do_pop && !do_push)
      count_next = count - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/alsu_result_tx.sv
// Queues ALSU results and sends each as a UART-style frame:
//   start(0), 7 data bits LSB first ({err, result}), optional parity, stop(1).
// Ports:
//   clk, rst (async, active-low)
//   result[5:0], err, result_valid : ALSU result capture strobe
//   tx         : serial line, idle high
//   busy       : frame in progress
//   fifo_count : queued entries, fifo_full : queue full
//   drop_cnt   : saturating count of results lost to overflow
module alsu_result_tx
  import alsu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [5:0]                    result,
  input  logic                          result_valid,
  input  logic                          err,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic [3:0]                    drop_cnt
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t          state;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [2:0]         bit_idx;
  logic [ENTRY_W-1:0] shift;
  logic               parity_bit;
  logic [ENTRY_W-1:0] head;
  logic               fifo_empty;
  logic               pop;
  logic               baud_done;

  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign baud_done = (baud_cnt == BAUD_LAST);

  alsu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (result_valid),
    .pop   (pop),
    .wdata ({err, result}),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Transmitter: tx and busy are set one state ahead so they change on the
  // same edge as the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shift      <= head;
            parity_bit <= entry_parity(head, PARITY_ODD);
            state      <= ST_START;
            tx         <= 1'b0;
            busy       <= 1'b1;
          end else begin
            tx   <= 1'b1;
            busy <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd6) begin
              if (PARITY_EN) begin
                state <= ST_PARITY;
                tx    <= parity_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= ST_STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= ST_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // A result is lost only when the queue is full and nothing leaves this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (result_valid && fifo_full && !pop && drop_cnt != 4'hF) begin
      drop_cnt <= drop_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_alsu_result_tx.sv
// Testbench for alsu_result_tx: an even-parity and an odd-parity instance
// driven by the same inputs, checked every cycle against a transaction-level
// model (queue of entries, frame start times, slot arithmetic on the tx line).
module tb_alsu_result_tx;

  localparam int CPB      = 4;
  localparam int DEPTH    = 4;
  localparam int FRAME    = 10 * CPB;
  localparam int POP_GAP  = FRAME + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] result = '0;
  logic       result_valid = 1'b0;
  logic       err = 1'b0;

  logic       tx, busy, fifo_full;
  logic [2:0] fifo_count;
  logic [3:0] drop_cnt;
  logic       tx_o, busy_o, fifo_full_o;
  logic [2:0] fifo_count_o;
  logic [3:0] drop_cnt_o;

  alsu_result_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .result(result), .result_valid(result_valid), .err(err),
    .tx(tx), .busy(busy), .fifo_count(fifo_count), .fifo_full(fifo_full), .drop_cnt(drop_cnt)
  );

  alsu_result_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .FIFO_DEPTH(DEPTH)) dut_odd (
    .clk(clk), .rst(rst), .result(result), .result_valid(result_valid), .err(err),
    .tx(tx_o), .busy(busy_o), .fifo_count(fifo_count_o), .fifo_full(fifo_full_o), .drop_cnt(drop_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         k;
  int         next_pop;
  int         last_pop;
  int         model_drop;
  logic [6:0] q [$];
  logic [6:0] cur;

  int n_cmp;
  int n_fail;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, k);
    end
  endtask

  // Expected line level: frame slots are start, 7 data bits, parity, stop.
  function automatic logic exp_tx(input logic odd);
    int off;
    int slot;
    off = k - last_pop;
    if (off < 0 || off >= FRAME) return 1'b1;
    slot = off / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 8) return (^cur) ^ odd;
    if (slot == 9) return 1'b1;
    return cur[slot-1];
  endfunction

  function automatic logic exp_busy();
    int off;
    off = k - last_pop;
    return (off >= 0 && off < FRAME);
  endfunction

  task automatic modelReset();
    q.delete();
    model_drop = 0;
    last_pop   = -1000;
    next_pop   = 0;
    cur        = '0;
  endtask

  // One clock edge of the model: the transmitter takes the head first, then
  // the new result is queued if there is room left.
  task automatic modelEdge(input logic v, input logic [6:0] entry);
    if (k >= next_pop && q.size() > 0) begin
      cur      = q.pop_front();
      last_pop = k;
      next_pop = k + POP_GAP;
    end
    if (v) begin
      if (q.size() < DEPTH) q.push_back(entry);
      else if (model_drop < 15) model_drop++;
    end
  endtask

  task automatic checkAll();
    checkOutput("tx",         tx,           exp_tx(1'b0));
    checkOutput("tx_odd",     tx_o,         exp_tx(1'b1));
    checkOutput("busy",       busy,         exp_busy());
    checkOutput("busy_odd",   busy_o,       exp_busy());
    checkOutput("count",      fifo_count,   q.size());
    checkOutput("count_odd",  fifo_count_o, q.size());
    checkOutput("full",       fifo_full,    q.size() == DEPTH);
    checkOutput("full_odd",   fifo_full_o,  q.size() == DEPTH);
    checkOutput("drop",       drop_cnt,     model_drop);
    checkOutput("drop_odd",   drop_cnt_o,   model_drop);
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] r, input logic e);
    result_valid = v;
    result       = r;
    err          = e;
    @(posedge clk);
    k++;
    modelEdge(v, {e, r});
    #1;
    checkAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 6'($urandom), 1'($urandom));
  endtask

  // Reset is asserted away from the clock edge; outputs must clear at once.
  task automatic doReset();
    result_valid = 1'b0;
    rst = 1'b0;
    modelReset();
    #2;
    checkOutput("rst_tx",    tx,         1'b1);
    checkOutput("rst_busy",  busy,       1'b0);
    checkOutput("rst_count", fifo_count, 0);
    checkOutput("rst_drop",  drop_cnt,   0);
    checkOutput("rst_full",  fifo_full,  1'b0);
    @(posedge clk);
    k++;
    #1;
    checkAll();
    rst = 1'b1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    k      = 0;
    rst    = 1'b1;
    modelReset();
    #1;
    doReset();

    // Single frame: 0x2D with err=0, then full frame time on an idle line.
    $display("[TB] single frame 0x2D");
    applyStimulus(1'b1, 6'h2D, 1'b0);
    checkOutput("lat_tx_high", tx, 1'b1);
    applyStimulus(1'b0, 6'h00, 1'b0);
    checkOutput("lat_tx_low", tx, 1'b0);
    idleCycles(FRAME + 4);

    // err set, result zero: only the top data bit is high, parity 1 (odd build 0).
    $display("[TB] err frame");
    applyStimulus(1'b1, 6'h00, 1'b1);
    idleCycles(FRAME + 4);

    // Six back-to-back pushes while idle: one popped, four queued, one dropped.
    $display("[TB] burst of six");
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 6'(8 * i + 3), 1'(i & 1));
    checkOutput("burst_full", fifo_full, 1'b1);
    checkOutput("burst_drop", drop_cnt, 1);
    applyStimulus(1'b0, 6'h00, 1'b0);
    idleCycles(5 * POP_GAP + 5);

    // Keep pushing while full: the drop counter saturates.
    $display("[TB] saturation");
    for (int i = 0; i < 25; i++)
      applyStimulus(1'b1, 6'($urandom), 1'($urandom));
    checkOutput("sat_drop", drop_cnt, 15);

    // Push on exactly the edge where the full FIFO gives up its head.
    $display("[TB] push on pop edge");
    for (int i = 0; i < 2 * POP_GAP && (k + 1) < next_pop; i++)
      applyStimulus(1'b0, 6'h00, 1'b0);
    applyStimulus(1'b1, 6'h3C, 1'b0);
    checkOutput("edge_pop_count", fifo_count, 4);
    checkOutput("edge_pop_drop",  drop_cnt,   15);
    idleCycles(5 * POP_GAP + 5);

    // Randomised traffic with occasional bursts.
    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 1200; i++) begin
      int pct;
      pct = ((i % 300) < 12) ? 85 : 4;
      applyStimulus(1'($urandom_range(0, 99) < pct), 6'($urandom), 1'($urandom));
    end
    idleCycles(5 * POP_GAP);

    // Reset in the middle of the data bits, then a clean frame afterwards.
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 6'h2A, 1'b1);
    applyStimulus(1'b1, 6'h11, 1'b0);
    for (int i = 0; i < 3 * CPB && (k - last_pop) < 3 * CPB; i++)
      applyStimulus(1'b0, 6'h00, 1'b0);
    checkOutput("mid_busy", busy, 1'b1);
    doReset();
    applyStimulus(1'b1, 6'h15, 1'b1);
    idleCycles(FRAME + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alsu_result_tx.md
Name: alsu_result_tx

Overview:
- Downstream stage of the ALSU. Captures each ALSU result together with its invalid-opcode indication and queues it in a 4-entry FIFO.
- Serialises each queued entry as a UART-style frame on a single tx line, for board-level observation and logging.
- Decouples ALSU result rate from the slow serial line; overflow is counted, never stalls the ALSU.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit (min 2; board builds override, e.g. 868).
- PARITY_EN, 1, 1 = append parity bit; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).
- FIFO_DEPTH, 4, entries; power of two, 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset. One clock; reset is asynchronous and active-low.
- result  input  6  ALSU out value.
- result_valid  input  1  single-cycle strobe: result/err valid this cycle.
- err  input  1  ALSU was in invalid-opcode state for this result (leds non-zero).
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently queued.
- fifo_full  output  1  fifo_count == FIFO_DEPTH.
- drop_cnt  output  4  saturating count of results dropped on overflow.

Behaviour:
- Reset (rst=0, async): tx=1, busy=0, fifo_count=0, fifo_full=0, drop_cnt=0, FSM=IDLE, all counters 0. Any frame in progress is aborted; tx is high immediately.
- Entry format: 7 bits {err, result[5:0]}.
- Push: on a clk edge with result_valid=1. The entry is written if not full, or if a pop occurs on the same edge (full + simultaneous pop = accepted, count unchanged).
- Drop: push while full with no same-edge pop → entry discarded, drop_cnt+1, saturating at 15.
- Pop: only by the FSM in IDLE when fifo_count>0. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push+pop when empty: not possible; IDLE sees the new entry on the next cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, busy=0. If fifo_count>0: pop into shift register, compute parity over 7 bits, go START, reset baud counter.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA, bit_idx=0.
  - DATA: tx=shift[bit_idx], LSB first, each bit CLKS_PER_BIT cycles. After bit 6 → PARITY if PARITY_EN, else STOP.
  - PARITY: tx = even: XOR of 7 bits; odd: inverted. Lasts CLKS_PER_BIT cycles → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles → IDLE.
- busy=1 in every state except IDLE.
- Frame length: 10*CLKS_PER_BIT cycles (9*CLKS_PER_BIT without parity). Back-to-back frames are separated by exactly one IDLE cycle.
- Latency: entry written on edge N into an empty FIFO → popped on edge N+1 → tx low after edge N+1 (start of START).
- result/err are sampled only on push; changes mid-frame do not affect the current frame.
- All outputs are registered (tx from FSM register; fifo_count/full from pointer logic).

Decomposition:
- Shared package alsu_pkg: FSM state encoding (IDLE=0..STOP=4, 3-bit), ENTRY_W=7, opcode constants already used by the ALSU.
- One sub-module: alsu_sync_fifo (parameterised width/depth, push/pop, count, full, empty; write-when-full-with-pop allowed).
- The FSM, baud counter and parity live in alsu_result_tx.

Test Plan (defaults: CLKS_PER_BIT=4, PARITY_EN=1, even):
- Single push result=6'h2D, err=0 into empty FIFO → tx low after next edge; bit sequence 0,1,0,1,1,0,1,0,0,1 (start, 7 data LSB-first, parity=0, stop), each held 4 cycles; busy low after 40 cycles.
- err=1, result=6'h00 → data bits 0,0,0,0,0,0,1; parity 1; PARITY_ODD=1 build → parity 0.
- 6 pushes on consecutive cycles while idle → first popped, 4 queued, fifo_full=1, 1 dropped: drop_cnt=1. All 5 accepted frames are transmitted in order, 41 cycles apart.
- 20 pushes while full and no pop → drop_cnt saturates at 15.
- Push on the exact edge where IDLE pops from a full FIFO → accepted, fifo_count stays 4, drop_cnt unchanged.
- Assert rst=0 mid-DATA → tx=1, busy=0, fifo_count=0 asynchronously. After release, a new push transmits a clean frame.
